lfsr_sequencer: RTL
===================

# lfsr_sequencer

Run/pause/step/seed controller for the 8-bit LFSR display datapath. Turns three push-buttons, an 8-bit seed switch bank and a 2-bit speed switch into single-cycle `lfsr_step` / `lfsr_load` strobes plus a seed value for the LFSR register. Also keeps a step count since the last seed load. It replaces the fixed free-running 1 s enable.

## Interface

Parameters:
- `STEP_DIV`, 50000000: clock cycles per step at speed 0; must be a multiple of 64.
- `DEBOUNCE_CYCLES`, 1000000: stable-level cycles needed to accept a button change; at least 2.
- `RST_SEED`, 8'h01: `lfsr_seed` value after reset; must be nonzero.

Ports:
- `sys_clk`, in, 1: clock.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `btn_run`, in, 1: run/pause toggle button; asynchronous, active-high.
- `btn_step`, in, 1: single-step button; asynchronous, active-high.
- `btn_load`, in, 1: seed-load button; asynchronous, active-high.
- `sw_seed`, in, 8: seed switches; quasi-static.
- `sw_speed`, in, 2: speed select; quasi-static.
- `lfsr_step`, out, 1: one-cycle advance strobe to the LFSR.
- `lfsr_load`, out, 1: one-cycle load strobe; the LFSR takes `lfsr_seed`.
- `lfsr_seed`, out, 8: seed value, valid whenever `lfsr_load` is high.
- `running`, out, 1: 1 in state RUN.
- `step_cnt`, out, 16: number of `lfsr_step` pulses since the last load or reset; wraps.

## Operation

**Button front end (identical per button)**
- 2-flop synchronizer.
- Debounce counter: the accepted level changes only after the synchronized input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
- A press event is a 0->1 change of the accepted level and lasts one cycle.

**FSM states:** IDLE (paused), RUN, LOAD. Reset state is IDLE.

**Event priority in one cycle:** load > run > step. Lower-priority events in that same cycle are dropped.

**Transitions and actions**
- load press, from any state -> LOAD.
  - LOAD lasts one cycle, then goes to IDLE.
  - In LOAD: `lfsr_seed` <= `sw_seed`, or 8'h01 if `sw_seed` == 0 (zero is a lock-up state). `lfsr_load` = 1, `tick_cnt` <= 0, `step_cnt` <= 0.
- run press: IDLE -> RUN with `tick_cnt` <= 0; RUN -> IDLE.
- step press: in IDLE, produces one `lfsr_step` pulse. In RUN or LOAD it is ignored.
- In RUN:
  - `terminal` = (`STEP_DIV` >> (2*`sw_speed`)) - 1.
  - `tick_cnt` increments each cycle.
  - When `tick_cnt` >= `terminal`: pulse `lfsr_step` and set `tick_cnt` <= 0. Using >= covers a speed increase mid-count.
- Leaving RUN freezes `tick_cnt`; re-entering RUN clears it.
- `step_cnt` increments on every `lfsr_step` and wraps 16'hFFFF -> 0.
- `lfsr_step` and `lfsr_load` are never high in the same cycle.

## Timing

**Outputs**
- All outputs are registered.
- Reset values: `lfsr_step` = 0, `lfsr_load` = 0, `lfsr_seed` = `RST_SEED`, `running` = 0, `step_cnt` = 0.

**Latencies**
- Button: a press held stable produces its event `DEBOUNCE_CYCLES` + 2 cycles after the input rises, ±1 cycle.
- Event to output: `lfsr_load`, a step-triggered `lfsr_step` and `running` each appear 1 cycle after the event cycle.
- RUN: the first `lfsr_step` comes `terminal` + 1 cycles after `running` rises. After that, pulses are exactly `terminal` + 1 cycles apart while `sw_speed` is constant.

**Reset mid-operation**
- Asserting reset returns everything to reset values immediately.
- No strobe is issued during reset or on the first cycle after it.
- A button held through reset release does not produce a press event.

## Test plan

Bench parameters: `STEP_DIV` = 64, `DEBOUNCE_CYCLES` = 4.

1. Reset, then press `btn_step` three times while in IDLE -> three single-cycle `lfsr_step` pulses, `step_cnt` = 3, `running` = 0, `lfsr_load` never asserted.
2. Press run with `sw_speed` = 0, wait 200 cycles, press run again -> `running` toggles 1 then 0. `lfsr_step` pulses every 64 cycles, first one 64 cycles after `running` rises. No pulses after the pause.
3. While in RUN, change `sw_speed` 0 -> 3 while `tick_cnt` is about 40 -> next `lfsr_step` on the following cycle, then every 1 cycle (64 >> 6 = 1; `terminal` = 0).
4. `sw_seed` = 8'hA5, press load while running -> `lfsr_load` for 1 cycle with `lfsr_seed` = 8'hA5. State then IDLE, `running` = 0, `step_cnt` = 0.
5. `sw_seed` = 8'h00, press load -> `lfsr_seed` = 8'h01. Press load and run in the same cycle -> load only, end in IDLE.
6. Bounce `btn_step` with high pulses of 1-3 cycles, then hold it high for 10 cycles -> exactly one `lfsr_step`. Assert `sys_rst_n` low mid-RUN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/lfsr_sequencer.sv
// lfsr_sequencer
//   Run/pause/step/seed controller for the 8-bit LFSR display datapath.
//   Three debounced push-buttons drive a small IDLE/RUN/LOAD FSM that issues
//   single-cycle advance/load strobes to the LFSR register. A programmable
//   tick divider produces the advance strobe while running.
//
// Ports
//   sys_clk, sys_rst_n   clock, async active-low reset
//   btn_run/step/load    raw asynchronous push-buttons (active-high)
//   sw_seed[7:0]         seed switches (quasi-static)
//   sw_speed[1:0]        step rate: STEP_DIV >> (2*sw_speed) cycles per step
//   lfsr_step            one-cycle advance strobe
//   lfsr_load            one-cycle load strobe, LFSR takes lfsr_seed
//   lfsr_seed[7:0]       seed value (never zero)
//   running              high while in RUN
//   step_cnt[15:0]       lfsr_step pulses since last load/reset, wraps

// Per-button front end: 2-flop synchronizer, debounce, rising-press event.
module lfsr_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          lvl;
    logic [CW-1:0] cnt;

    // The accepted level comes out of reset as "pressed": a button held
    // through reset release never yields an event, and a released button
    // just debounces down to 0 silently.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync  <= 2'b00;
            lvl   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                lvl   <= sync[1];
                cnt   <= '0;
                press <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module lfsr_sequencer #(
    parameter int             STEP_DIV        = 50000000,
    parameter int             DEBOUNCE_CYCLES = 1000000,
    parameter logic [7:0]     RST_SEED        = 8'h01
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        btn_load,
    input  logic [7:0]  sw_seed,
    input  logic [1:0]  sw_speed,
    output logic        lfsr_step,
    output logic        lfsr_load,
    output logic [7:0]  lfsr_seed,
    output logic        running,
    output logic [15:0] step_cnt
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;

    localparam int TW = $clog2(STEP_DIV);
    localparam logic [TW:0] DIV = (TW+1)'(STEP_DIV);

    // ev[0]=step, ev[1]=run, ev[2]=load
    logic [2:0] btn_vec;
    logic [2:0] ev;
    assign btn_vec = {btn_load, btn_run, btn_step};

    for (genvar g = 0; g < 3; g++) begin : g_btn
        lfsr_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .btn       (btn_vec[g]),
            .press     (ev[g])
        );
    end

    logic ev_step, ev_run, ev_load;
    assign ev_step = ev[0];
    assign ev_run  = ev[1];
    assign ev_load = ev[2];

    logic [1:0]    state, state_nx;
    logic [TW-1:0] tick_cnt;
    logic [TW:0]   term_full;
    logic          tick_done;
    logic          do_step;

    // Terminal recomputed every cycle; >= lets a mid-count speed-up fire at once.
    assign term_full = (DIV >> {sw_speed, 1'b0}) - (TW+1)'(1);
    assign tick_done = ({1'b0, tick_cnt} >= term_full);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ev_load) state_nx = LOAD; else if (ev_run) state_nx = RUN;
            RUN:     if (ev_load) state_nx = LOAD; else if (ev_run) state_nx = IDLE;
            LOAD:    state_nx = ev_load ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Load and run presses pre-empt both step sources, so step and load
    // strobes are mutually exclusive by construction.
    assign do_step = !ev_load && !ev_run &&
                     (((state == IDLE) && ev_step) || ((state == RUN) && tick_done));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            running   <= 1'b0;
            lfsr_step <= 1'b0;
            lfsr_load <= 1'b0;
            lfsr_seed <= RST_SEED;
            step_cnt  <= '0;
            tick_cnt  <= '0;
        end else begin
            state     <= state_nx;
            running   <= (state_nx == RUN);
            lfsr_step <= do_step;
            lfsr_load <= ev_load;

            if (ev_load) begin
                lfsr_seed <= (sw_seed == 8'h00) ? 8'h01 : sw_seed;
                step_cnt  <= '0;
            end else if (do_step) begin
                step_cnt  <= step_cnt + 16'd1;
            end

            // tick_cnt holds its value outside RUN and restarts on entry.
            if (ev_load || ((state == IDLE) && ev_run)) begin
                tick_cnt <= '0;
            end else if ((state == RUN) && !ev_run) begin
                tick_cnt <= tick_done ? '0 : tick_cnt + TW'(1);
            end
        end
    end
endmodule
